// File: rtl/addsub_arb_pkg.sv
// rtl/addsub_arb_pkg.sv - shared constants for the add/sub sharing arbiter
package addsub_arb_pkg;

    localparam int OPND_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [0:0] RSP_EMPTY = 1'b0;
    localparam logic [0:0] RSP_FULL  = 1'b1;

endpackage

// File: rtl/adder_subtractor_8bit.sv
// rtl/adder_subtractor_8bit.sv - combinational 8-bit adder/subtractor shared unit
module adder_subtractor_8bit
    import addsub_arb_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Ctl,
    input  logic       enable,
    output logic [7:0] Sum_Difference,
    output logic       Cout
);

    logic [7:0] b_eff;
    logic [8:0] total;

    // Subtract as A + ~B + 1 so the carry out reads as "no borrow"; idle output is zero
    always_comb begin
        b_eff = (Ctl == OP_SUB) ? ~B : B;
        total = {1'b0, A} + {1'b0, b_eff} + {8'b0, Ctl};
        if (enable) begin
            Sum_Difference = total[7:0];
            Cout           = total[8];
        end else begin
            Sum_Difference = 8'd0;
            Cout           = 1'b0;
        end
    end

endmodule

// File: rtl/addsub_share_arbiter_rr_pick_first.sv
// rtl/addsub_share_arbiter_rr_pick_first.sv - rotate-priority first-one picker
module rr_pick_first #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int j;

    // Scan from ptr upward with wrap, taking the first requester found
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/addsub_share_arbiter.sv
// rtl/addsub_share_arbiter.sv - round-robin sharing of one add/sub unit; ADDSUB_ARB_STATS_EN adds op/stall counters
module addsub_share_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [8*NUM_REQ-1:0]  req_a,
    input  logic [8*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]    req_ctl,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [7:0]            rsp_result,
    output logic                  rsp_cout,
    output logic                  rsp_ctl
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [15:0]           op_count,
    output logic [15:0]           stall_count
`endif
);

    logic [0:0]        rsp_state_q, rsp_state_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [7:0]        rsp_result_q, rsp_result_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_ctl_q, rsp_ctl_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic              ctl_q, ctl_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               can_issue;
    logic               grant;
    logic [7:0]         unit_res;
    logic               unit_cout;

    rr_pick_first #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    adder_subtractor_8bit u_addsub (
        .A              (a_d),
        .B              (b_d),
        .Ctl            (ctl_d),
        .enable         (grant),
        .Sum_Difference (unit_res),
        .Cout           (unit_cout)
    );

    assign rsp_valid  = (rsp_state_q == RSP_FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_ctl    = rsp_ctl_q;

    // Grant decision and unit operand steering; operands hold when idle to avoid toggling
    always_comb begin
        can_issue = !rsp_valid || rsp_ready;
        grant     = can_issue && pick_any;
        req_ready = can_issue ? pick_gnt : '0;
        a_d       = a_q;
        b_d       = b_q;
        ctl_d     = ctl_q;
        if (grant) begin
            a_d   = req_a[int'(pick_idx)*OPND_W +: OPND_W];
            b_d   = req_b[int'(pick_idx)*OPND_W +: OPND_W];
            ctl_d = req_ctl[pick_idx];
        end
    end

    // Response register next state and round-robin pointer advance
    always_comb begin
        rsp_state_d  = rsp_state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_ctl_d    = rsp_ctl_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant) begin
            rsp_state_d  = RSP_FULL;
            rsp_id_d     = pick_idx;
            rsp_result_d = unit_res;
            rsp_cout_d   = unit_cout;
            rsp_ctl_d    = ctl_d;
            if (int'(pick_idx) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = pick_idx + ID_W'(1);
            end
        end else if (rsp_ready) begin
            rsp_state_d = RSP_EMPTY;
        end
    end

    // State registers with synchronous reset that drops any held response
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_state_q  <= RSP_EMPTY;
            rsp_id_q     <= '0;
            rsp_result_q <= 8'd0;
            rsp_cout_q   <= 1'b0;
            rsp_ctl_q    <= 1'b0;
            rr_ptr_q     <= '0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            ctl_q        <= 1'b0;
        end else begin
            rsp_state_q  <= rsp_state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ctl_q    <= rsp_ctl_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctl_q        <= ctl_d;
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;

    // Saturating counters of grants and of cycles where someone waited without a grant
    always_comb begin
        op_count_d    = op_count_q;
        stall_count_d = stall_count_q;
        if (grant && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
        end
        if (|req_valid && !grant && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q    <= 16'd0;
            stall_count_q <= 16'd0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end
`endif

endmodule
